// File: rtl/pad_event_unit_if.sv
// CPU bus view of the pad event unit: select, strobes, word address, data and irq.
// Latency: rdata is combinational from addr/sel; irq is a registered level.
// Backpressure: none; every strobe is accepted on the cycle it is asserted.
interface pad_event_unit_if;
    logic        sel;
    logic        re;
    logic        we;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        irq;

    modport master (output sel, re, we, addr, wdata, input rdata, irq);
    modport slave  (input sel, re, we, addr, wdata, output rdata, irq);
endinterface

// File: rtl/pad_event_unit.sv
// Paces gamepad polls, debounces button words and reports changes as state, sticky edges and a FIFO.
// Latency: commit one cycle after the debounce count completes; events drain one bit per cycle over 16 cycles.
// Backpressure: none upstream; FIFO overflow drops events and sets a sticky OVF flag.
module pad_event_unit #(
    parameter int POLL_CYCLES = 1000,
    parameter int DEBOUNCE    = 3,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic             poll_req,
    input  logic             spi_busy,
    input  logic             spi_valid,
    input  logic [15:0]      spi_rdata,
    pad_event_unit_if.slave  bus
);
    localparam int TW = $clog2(POLL_CYCLES);
    localparam int PW = $clog2(FIFO_DEPTH);

    typedef enum logic {S_IDLE, S_SCAN} fsm_t;

    fsm_t            fsm_q, fsm_d;
    logic [3:0]      idx_q, idx_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic            pend_q, pend_d;
    logic            poll_q, poll_d;
    logic [15:0]     last_raw_q, last_raw_d;
    logic [3:0]      stable_q, stable_d;
    logic [15:0]     btn_q, btn_d;
    logic [15:0]     pressed_q, pressed_d;
    logic [15:0]     released_q, released_d;
    logic [15:0]     chg_q, chg_d;
    logic [15:0]     kind_q, kind_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW:0]     count_q, count_d;
    logic            ovf_q, ovf_d;
    logic            irq_q, irq_d;
    logic [4:0]      fifo_mem [FIFO_DEPTH];

    logic            expire, commit, push_req, push, pop, full;
    logic [15:0]     raw, rise, fall;
    logic [4:0]      ev_dat, head;
    logic            unused_wdata;

    assign unused_wdata = ^bus.wdata[30:16];

    assign expire   = (timer_q == TW'(POLL_CYCLES - 1));
    assign raw      = ~spi_rdata;
    assign rise     = last_raw_q & ~btn_q;
    assign fall     = ~last_raw_q & btn_q;
    assign commit   = (fsm_q == S_IDLE) && (stable_q == 4'(DEBOUNCE)) && (last_raw_q != btn_q);
    assign full     = (count_q == (PW+1)'(FIFO_DEPTH));
    assign push_req = (fsm_q == S_SCAN) && chg_q[idx_q];
    assign push     = push_req && !full;
    assign pop      = bus.sel && bus.re && (bus.addr == 2'd3) && (count_q != '0);
    assign ev_dat   = {kind_q[idx_q], idx_q};
    assign head     = fifo_mem[rd_ptr_q];
    assign poll_req = poll_q;
    assign bus.irq  = irq_q;

    // Scan sequencer: walks the changed-bit mask one index per cycle after each commit.
    always_comb begin
        fsm_d = fsm_q;
        idx_d = idx_q;
        case (fsm_q)
            S_IDLE: if (commit) begin
                fsm_d = S_SCAN;
                idx_d = '0;
            end
            S_SCAN: begin
                idx_d = idx_q + 4'd1;
                if (idx_q == 4'd15) fsm_d = S_IDLE;
            end
            default: fsm_d = S_IDLE;
        endcase
    end

    // Scan sequencer state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q <= S_IDLE;
            idx_q <= '0;
        end else begin
            fsm_q <= fsm_d;
            idx_q <= idx_d;
        end
    end

    // Poll pacing, debounce, commit, sticky edges and FIFO bookkeeping.
    always_comb begin
        timer_d    = expire ? '0 : timer_q + 1'b1;
        // A request that hits a busy controller waits; later expiries fold into it.
        poll_d     = !spi_busy && (expire || pend_q);
        pend_d     = spi_busy && (expire || pend_q);

        last_raw_d = last_raw_q;
        stable_d   = stable_q;
        if (spi_valid && fsm_q == S_IDLE) begin
            if (raw == last_raw_q) begin
                if (stable_q != 4'(DEBOUNCE)) stable_d = stable_q + 4'd1;
            end else begin
                last_raw_d = raw;
                stable_d   = 4'd1;
            end
        end

        btn_d      = btn_q;
        chg_d      = chg_q;
        kind_d     = kind_q;
        pressed_d  = pressed_q;
        released_d = released_q;
        if (bus.sel && bus.we && bus.addr == 2'd1) pressed_d  = pressed_q & ~bus.wdata[15:0];
        if (bus.sel && bus.we && bus.addr == 2'd2) released_d = released_q & ~bus.wdata[15:0];
        // Sets are applied after the clears so a same-cycle W1C cannot lose an edge.
        if (commit) begin
            btn_d      = last_raw_q;
            chg_d      = rise | fall;
            kind_d     = last_raw_q;
            pressed_d  = pressed_d | rise;
            released_d = released_d | fall;
        end

        ovf_d = ovf_q;
        if (bus.sel && bus.we && bus.addr == 2'd3 && bus.wdata[31]) ovf_d = 1'b0;
        if (push_req && full) ovf_d = 1'b1;

        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        if (push && !pop) count_d = count_q + 1'b1;
        if (!push && pop) count_d = count_q - 1'b1;
        irq_d    = (count_d != '0);
    end

    // Datapath state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer_q    <= '0;
            pend_q     <= 1'b0;
            poll_q     <= 1'b0;
            last_raw_q <= '0;
            stable_q   <= '0;
            btn_q      <= '0;
            pressed_q  <= '0;
            released_q <= '0;
            chg_q      <= '0;
            kind_q     <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            ovf_q      <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            timer_q    <= timer_d;
            pend_q     <= pend_d;
            poll_q     <= poll_d;
            last_raw_q <= last_raw_d;
            stable_q   <= stable_d;
            btn_q      <= btn_d;
            pressed_q  <= pressed_d;
            released_q <= released_d;
            chg_q      <= chg_d;
            kind_q     <= kind_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            ovf_q      <= ovf_d;
            irq_q      <= irq_d;
        end
    end

    // Event storage; contents are only meaningful between the pointers, so no reset.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr_q] <= ev_dat;
    end

    // Register read mux.
    always_comb begin
        bus.rdata = '0;
        if (bus.sel) begin
            case (bus.addr)
                2'd0:    bus.rdata = {16'b0, btn_q};
                2'd1:    bus.rdata = {16'b0, pressed_q};
                2'd2:    bus.rdata = {16'b0, released_q};
                default: bus.rdata = {ovf_q, 22'b0, (count_q != '0), 2'b0,
                                      (count_q != '0) & head[4], 1'b0,
                                      (count_q != '0) ? head[3:0] : 4'b0};
            endcase
        end
    end
endmodule

// File: tb/tb_pad_event_unit.sv
module tb_pad_event_unit;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        poll_req;
    logic        spi_busy;
    logic        spi_valid;
    logic [15:0] spi_rdata;
    int          total = 0;
    int          bad = 0;

    pad_event_unit_if bus();

    pad_event_unit #(.POLL_CYCLES(64), .DEBOUNCE(3), .FIFO_DEPTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .poll_req(poll_req), .spi_busy(spi_busy),
        .spi_valid(spi_valid), .spi_rdata(spi_rdata), .bus(bus)
    );

    always #5 clk = ~clk;

    // Reference model: button-level view of the block.
    logic [15:0] m_state, m_pressed, m_released, m_last;
    int          m_cnt;
    bit          m_ovf;
    logic [4:0]  m_q[$];

    function automatic void model_reset();
        m_state = '0; m_pressed = '0; m_released = '0; m_last = '0;
        m_cnt = 0; m_ovf = 0; m_q.delete();
    endfunction

    function automatic void model_sample(input logic [15:0] raw);
        if (raw == m_last) begin
            if (m_cnt < 3) m_cnt++;
        end else begin
            m_last = raw;
            m_cnt = 1;
        end
        if (m_cnt == 3 && m_last != m_state) begin
            for (int i = 0; i < 16; i++) begin
                if (m_last[i] != m_state[i]) begin
                    if (m_q.size() < 8) m_q.push_back({m_last[i], 4'(i)});
                    else m_ovf = 1;
                    if (m_last[i]) m_pressed[i] = 1'b1;
                    else m_released[i] = 1'b1;
                end
            end
            m_state = m_last;
        end
    endfunction

    function automatic logic [31:0] model_read(input int a);
        logic [4:0] e;
        case (a)
            0: return 32'(m_state);
            1: return 32'(m_pressed);
            2: return 32'(m_released);
            default: begin
                if (m_q.size() == 0) return m_ovf ? 32'h8000_0000 : 32'h0;
                e = m_q[0];
                return (m_ovf ? 32'h8000_0000 : 32'h0) + 32'h100 + 32'(e[4]) * 32 + 32'(e[3:0]);
            end
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input int a, output logic [31:0] d);
        bus.sel = 1'b1; bus.re = 1'b1; bus.addr = 2'(a);
        #1 d = bus.rdata;
        tick();
        bus.sel = 1'b0; bus.re = 1'b0;
        if (a == 3 && m_q.size() > 0) void'(m_q.pop_front());
    endtask

    task automatic rd_model(input int a, input string tag);
        logic [31:0] exp, d;
        exp = model_read(a);
        rd(a, d);
        chk(tag, d, exp);
    endtask

    task automatic wr(input int a, input logic [31:0] d);
        bus.sel = 1'b1; bus.we = 1'b1; bus.addr = 2'(a); bus.wdata = d;
        tick();
        bus.sel = 1'b0; bus.we = 1'b0;
    endtask

    task automatic sample(input logic [15:0] v, input int gap);
        spi_rdata = v; spi_valid = 1'b1;
        tick();
        spi_valid = 1'b0;
        model_sample(~v);
        repeat (gap) tick();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.sel = 0; bus.re = 0; bus.we = 0; bus.addr = 0; bus.wdata = 0;
        spi_valid = 0; spi_busy = 0; spi_rdata = 16'hFFFF;
        tick(); tick();
        rst_n = 1'b1;
        model_reset();
    endtask

    // Peeks all registers without strobes (safe while reset is held).
    task automatic check_zero(input string tag);
        for (int a = 0; a < 4; a++) begin
            bus.sel = 1'b1; bus.addr = 2'(a);
            #1 chk($sformatf("%s_reg%0d", tag, a), bus.rdata, 32'h0);
        end
        bus.sel = 1'b0;
        chk({tag, "_irq"}, 32'(bus.irq), 32'h0);
        chk({tag, "_poll"}, 32'(poll_req), 32'h0);
    endtask

    task automatic poll_run(input bit busy, output int first, output int second, output int cnt);
        first = -1; second = -1; cnt = 0;
        for (int n = 1; n <= 130; n++) begin
            spi_busy = busy && n >= 60 && n <= 70;
            tick();
            if (poll_req) begin
                cnt++;
                if (first < 0) first = n;
                else if (second < 0) second = n;
            end
        end
        spi_busy = 1'b0;
    endtask

    initial begin
        logic [31:0] d;
        int          f, s, c;
        logic [15:0] pool [4];
        int          idxs [8] = '{1, 3, 5, 7, 8, 10, 12, 14};

        do_reset();
        check_zero("reset");

        // Debounce: two samples hold, third commits bit 0 press.
        sample(16'hFFFE, 20);
        sample(16'hFFFE, 20);
        rd(0, d); chk("deb_state_2", d, 32'h0);
        sample(16'hFFFE, 20);
        rd(0, d); chk("deb_state_3", d, 32'h1);
        rd(1, d); chk("deb_pressed", d, 32'h1);
        chk("deb_irq1", 32'(bus.irq), 32'h1);
        rd(3, d); chk("deb_event", d, 32'h120);
        rd(3, d); chk("deb_empty", d, 32'h0);
        chk("deb_irq0", 32'(bus.irq), 32'h0);

        // Reset while the scan is in progress, then the poll schedule restarts.
        sample(16'h0000, 20);
        sample(16'h0000, 20);
        sample(16'h0000, 6);
        rst_n = 1'b0;
        #1 check_zero("midscan");
        tick();
        rst_n = 1'b1;
        model_reset();
        poll_run(0, f, s, c);
        chk("poll_first", 32'(f), 32'd64);
        chk("poll_second", 32'(s), 32'd128);
        chk("poll_count", 32'(c), 32'd2);
        rd(3, d); chk("midscan_noevent", d, 32'h0);

        do_reset();
        poll_run(1, f, s, c);
        chk("busy_first", 32'(f), 32'd71);
        chk("busy_second", 32'(s), 32'd128);
        chk("busy_count", 32'(c), 32'd2);

        // Multi-bit press: events pop in index order.
        do_reset();
        repeat (3) sample(16'hAA55, 20);
        rd(0, d); chk("aa55_state", d, 32'h55AA);
        for (int i = 0; i < 8; i++) begin
            rd(3, d); chk($sformatf("aa55_ev%0d", i), d, 32'h120 + 32'(idxs[i]));
        end
        rd(3, d); chk("aa55_empty", d, 32'h0);

        // Overflow: ten presses into eight slots.
        do_reset();
        repeat (3) sample(16'hFC00, 20);
        for (int i = 0; i < 8; i++) begin
            rd(3, d); chk($sformatf("ovf_ev%0d", i), d, 32'h8000_0120 + 32'(i));
        end
        rd(3, d); chk("ovf_empty", d, 32'h8000_0000);
        wr(3, 32'h8000_0000);
        rd(3, d); chk("ovf_clear", d, 32'h0);

        // W1C on the commit cycle loses to the set.
        do_reset();
        sample(16'hFFFE, 20);
        sample(16'hFFFE, 20);
        spi_rdata = 16'hFFFE; spi_valid = 1'b1;
        tick();
        spi_valid = 1'b0;
        bus.sel = 1'b1; bus.we = 1'b1; bus.addr = 2'd1; bus.wdata = 32'h1;
        tick();
        bus.sel = 1'b0; bus.we = 1'b0;
        model_sample(16'h0001);
        repeat (20) tick();
        rd(1, d); chk("race_pressed", d, 32'h1);
        wr(1, 32'h1);
        rd(1, d); chk("w1c_pressed", d, 32'h0);

        // Randomized traffic against the model.
        do_reset();
        for (int i = 0; i < 4; i++) pool[i] = 16'($urandom);
        for (int it = 0; it < 40; it++) begin
            logic [15:0] v;
            int          reps;
            int          act;
            v = pool[$urandom_range(0, 3)];
            reps = $urandom_range(1, 4);
            repeat (reps) sample(~v, 20);
            act = $urandom_range(0, 5);
            case (act)
                0: rd_model(0, "rnd_state");
                1: rd_model(1, "rnd_pressed");
                2: rd_model(2, "rnd_released");
                3: repeat (2) rd_model(3, "rnd_event");
                4: begin
                    logic [15:0] m;
                    m = 16'($urandom);
                    if ($urandom_range(0, 1) == 1) begin
                        wr(1, 32'(m)); m_pressed &= ~m; rd_model(1, "rnd_w1c_p");
                    end else begin
                        wr(2, 32'(m)); m_released &= ~m; rd_model(2, "rnd_w1c_r");
                    end
                end
                default: begin
                    wr(3, 32'h8000_0000); m_ovf = 0; rd_model(3, "rnd_ovfclr");
                end
            endcase
            chk("rnd_irq", 32'(bus.irq), 32'(m_q.size() != 0));
        end
        while (m_q.size() > 0) rd_model(3, "rnd_drain");
        rd_model(3, "rnd_final");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
